psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Sits directly downstream of the systolic array and receives the skewed partial sums that leave the bottom of each array column.
- Writes or accumulates those sums into a per-row, per-column accumulator store of Accumulator_depth rows. This lets tiled K-dimension passes sum in place.
- On request, drains the finished result rows over a valid/ready stream to the output/writeback stage.

Parameters:
- SYS_COLS, 50, number of array columns (sys_cols).
- ROWS, 50, accumulator depth in rows (Accumulator_depth / A_rows).
- P_BITWIDTH, 24, width of each incoming partial sum.
- ACC_BITWIDTH, 32, width of each accumulator entry; must be ≥ P_BITWIDTH.
- CNT_W, $clog2(ROWS+1), width of row counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- accumulate  in  1  latched at start: 1 = add to stored value, 0 = overwrite.
- drain_en  in  1  latched at start: 1 = drain after collection, 0 = return to IDLE.
- num_rows  in  CNT_W  latched at start: rows expected per column, legal range 1..ROWS.
- psum_valid  in  SYS_COLS  per-column valid for psum_in.
- psum_in  in  SYS_COLS*P_BITWIDTH  column j occupies bits [j*P_BITWIDTH +: P_BITWIDTH]; signed two's complement.
- out_valid  out  1  drain row valid.
- out_ready  in  1  downstream ready.
- out_data  out  SYS_COLS*ACC_BITWIDTH  row being drained; same column packing as psum_in.
- out_row  out  CNT_W  index of the row on out_data.
- busy  out  1  high in COLLECT or DRAIN.
- done  out  1  one-cycle pulse at the end of a pass.
- err  out  1  sticky error flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters 0; every accumulator entry 0. Outputs out_valid, out_data, out_row, busy, done, err all 0.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE → COLLECT when start=1 and 1 ≤ num_rows ≤ ROWS. On that transition, latch accumulate, drain_en and num_rows, zero every column write counter wc[j], and clear err.
- start=1 in IDLE with num_rows=0 or num_rows>ROWS: stay in IDLE, set err, no done pulse.
- start while busy: ignored, no effect.
- COLLECT, per column j, every cycle psum_valid[j]=1 and wc[j]<num_rows:
  - Update entry mem[wc[j]][j] to sext(psum_in_j) + (accumulate ? mem[wc[j]][j] : 0).
  - Arithmetic is modulo 2^ACC_BITWIDTH, with no saturation.
  - Then increment wc[j].
- Columns advance independently, which absorbs the array skew; column j typically lags column 0 by j cycles.
- psum_valid[j]=1 with wc[j]==num_rows (overrun): the sample is dropped, err is set, and the FSM is unaffected.
- psum_valid in IDLE or DRAIN is ignored and sets err.
- Collection completes in the first cycle all wc[j]==num_rows, counting writes made in the previous cycle. Call the cycle of the final write T.
  - drain_en=0: done pulses at T+1 and the FSM is back in IDLE at T+1.
  - drain_en=1: the FSM is in DRAIN at T+1 with out_row=0, out_valid=1, and out_data holding row 0 including the write made at T.
- DRAIN:
  - out_data and out_row stay stable while out_valid=1 and out_ready=0.
  - A handshake (out_valid & out_ready) on row r < num_rows-1 presents row r+1 on the next cycle, so a held-high out_ready gives one row per cycle.
  - Handshake on row num_rows-1: next cycle out_valid=0, done=1 and state=IDLE.
- Accumulator contents persist across passes; only overwrite mode (accumulate=0) or reset replaces them. Rows ≥ num_rows are untouched.
- Reset asserted mid-pass: immediate return to the reset state defined above; the partial pass is lost.
- busy=1 exactly when state≠IDLE.

Test Plan (SYS_COLS=4, ROWS=4, P_BITWIDTH=24, ACC_BITWIDTH=32):
- Overwrite pass, skewed arrival:
  - Stimulus: start, accumulate=0, drain_en=1, num_rows=2. Column j's valid is delayed j cycles. Column j sends row0=j+1, row1=10*(j+1).
  - Required: done=0 until the drain ends. Rows drained in order: {1,2,3,4} then {10,20,30,40}; out_row 0 then 1.
- Two-tile accumulate:
  - Stimulus: pass 1 overwrite with drain_en=0, all psums 5. Pass 2 with accumulate=1, drain_en=1, all psums -3 (0xFFFFFD).
  - Required: done pulses after pass 1 with no out_valid. Pass 2 drains every entry equal to 2.
- Drain backpressure:
  - Stimulus: num_rows=3, out_ready toggles 0,0,1,0,1,1.
  - Required: out_data/out_row held while ready=0. Exactly 3 handshakes, rows 0,1,2. done pulses one cycle after the third handshake.
- Wrap-around:
  - Stimulus: accumulate onto entry 0x7FFFFFFF with psum=1.
  - Required: entry reads 0x80000000; err=0.
- Errors:
  - Stimulus (a): start with num_rows=0. Required: err=1, state stays IDLE.
  - Stimulus (b): in a valid pass, a fifth psum_valid on column 2 with num_rows=4. Required: err=1, stored data unchanged.
  - Stimulus (c): the next valid start. Required: clears err.
- Reset mid-collect:
  - Stimulus: assert rst_n=0 after 1 of 3 rows has been written.
  - Required: busy=0, out_valid=0 and all entries read 0 on a subsequent overwrite-free drain (accumulate=1, psums 0).

Source files
------------

// File: rtl/psum_accumulator.sv
// ============================================================================
// Module      : psum_accumulator
// Description : Collects skewed per-column partial sums into a row/column
//               accumulator store, then optionally drains it row by row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_accumulator #(
  parameter int SYS_COLS     = 50,
  parameter int ROWS         = 50,
  parameter int P_BITWIDTH   = 24,
  parameter int ACC_BITWIDTH = 32,
  parameter int CNT_W        = $clog2(ROWS + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             accumulate,
  input  logic                             drain_en,
  input  logic [CNT_W-1:0]                 num_rows,
  input  logic [SYS_COLS-1:0]              psum_valid,
  input  logic [SYS_COLS*P_BITWIDTH-1:0]   psum_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SYS_COLS*ACC_BITWIDTH-1:0] out_data,
  output logic [CNT_W-1:0]                 out_row,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] c_rows_max = CNT_W'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_accumulate;
  logic                    r_drain_en;
  logic [CNT_W-1:0]        r_num_rows;
  logic [CNT_W-1:0]        r_wc  [SYS_COLS];
  logic [ACC_BITWIDTH-1:0] r_mem [ROWS][SYS_COLS];
  logic                    r_out_valid;
  logic [CNT_W-1:0]        r_out_row;
  logic                    r_done;
  logic                    r_err;

  logic [SYS_COLS-1:0]     w_wr_en;
  logic [SYS_COLS-1:0]     w_overrun;
  logic [ACC_BITWIDTH-1:0] w_sext    [SYS_COLS];
  logic [ACC_BITWIDTH-1:0] w_wr_data [SYS_COLS];
  logic                    w_all_full;
  logic                    w_num_ok;
  logic                    w_start_ok;
  logic                    w_start_bad;
  logic                    w_err_set;
  logic                    w_hs;
  logic                    w_last_row;

  // Completion looks at the counters as they will be after this cycle's writes,
  // so the state change lands in the cycle right after the final write.
  always_comb begin
    w_all_full = 1'b1;
    for (int j = 0; j < SYS_COLS; j++) begin
      w_wr_en[j]   = (r_state == S_COLLECT) && psum_valid[j] && (r_wc[j] < r_num_rows);
      w_overrun[j] = (r_state == S_COLLECT) && psum_valid[j] && (r_wc[j] >= r_num_rows);
      w_sext[j]    = ACC_BITWIDTH'($signed(psum_in[j*P_BITWIDTH +: P_BITWIDTH]));
      w_wr_data[j] = w_sext[j] + (r_accumulate ? r_mem[r_wc[j][IDX_W-1:0]][j] : '0);
      if ((r_wc[j] + CNT_W'(w_wr_en[j])) != r_num_rows)
        w_all_full = 1'b0;
    end
  end

  assign w_num_ok    = (num_rows != '0) && (num_rows <= c_rows_max);
  assign w_start_ok  = (r_state == S_IDLE) && start && w_num_ok;
  assign w_start_bad = (r_state == S_IDLE) && start && !w_num_ok;
  assign w_err_set   = (|w_overrun) || ((r_state != S_COLLECT) && (|psum_valid)) || w_start_bad;
  assign w_hs        = r_out_valid && out_ready;
  assign w_last_row  = (r_out_row == (r_num_rows - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_accumulate <= 1'b0;
      r_drain_en   <= 1'b0;
      r_num_rows   <= '0;
      r_out_valid  <= 1'b0;
      r_out_row    <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      for (int j = 0; j < SYS_COLS; j++) r_wc[j] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int j = 0; j < SYS_COLS; j++) r_mem[r][j] <= '0;
    end else begin
      r_done <= 1'b0;
      // A same-cycle error source wins over the clear from an accepted start.
      r_err  <= (w_start_ok ? 1'b0 : r_err) | w_err_set;

      for (int j = 0; j < SYS_COLS; j++) begin
        if (w_wr_en[j]) begin
          r_mem[r_wc[j][IDX_W-1:0]][j] <= w_wr_data[j];
          r_wc[j]                      <= r_wc[j] + CNT_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_accumulate <= accumulate;
            r_drain_en   <= drain_en;
            r_num_rows   <= num_rows;
            for (int j = 0; j < SYS_COLS; j++) r_wc[j] <= '0;
            r_state      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_all_full) begin
            if (r_drain_en) begin
              r_state     <= S_DRAIN;
              r_out_valid <= 1'b1;
              r_out_row   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (w_last_row) begin
              r_out_valid <= 1'b0;
              r_out_row   <= '0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_out_row <= r_out_row + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    if (r_out_valid)
      for (int j = 0; j < SYS_COLS; j++)
        out_data[j*ACC_BITWIDTH +: ACC_BITWIDTH] = r_mem[r_out_row[IDX_W-1:0]][j];
  end

  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_psum_accumulator.sv
// ============================================================================
// Module      : tb_psum_accumulator
// Description : Directed self-checking bench for psum_accumulator (4x4 store).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_accumulator;

  localparam int NC = 4;
  localparam int NR = 4;
  localparam int PW = 24;
  localparam int AW = 32;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             accumulate;
  logic             drain_en;
  logic [CW-1:0]    num_rows;
  logic [NC-1:0]    psum_valid;
  logic [NC*PW-1:0] psum_in;
  logic             out_valid;
  logic             out_ready;
  logic [NC*AW-1:0] out_data;
  logic [CW-1:0]    out_row;
  logic             busy;
  logic             done;
  logic             err;

  int n_pass  = 0;
  int n_total = 0;
  logic [PW-1:0] v [NR][NC];
  int extra_col = -1;
  bit saw_done;

  psum_accumulator #(
    .SYS_COLS(NC), .ROWS(NR), .P_BITWIDTH(PW), .ACC_BITWIDTH(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
    .drain_en(drain_en), .num_rows(num_rows), .psum_valid(psum_valid),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .busy(busy), .done(done), .err(err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [PW-1:0] val);
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < NC; j++) v[r][j] = val;
  endtask

  task automatic do_start(input bit acc, input bit drn, input int n);
    accumulate = acc;
    drain_en   = drn;
    num_rows   = CW'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Column j lags column 0 by j cycles when skew is set; extra_col sends one overrun sample.
  task automatic drive_collect(input int n, input bit skew);
    int last;
    last = n - 1 + (skew ? NC - 1 : 0);
    saw_done = 1'b0;
    for (int t = 0; t <= last; t++) begin
      psum_valid = '0;
      psum_in    = '0;
      for (int j = 0; j < NC; j++) begin
        int r;
        r = t - (skew ? j : 0);
        if (r >= 0 && r < n) begin
          psum_valid[j]          = 1'b1;
          psum_in[j*PW +: PW]    = v[r][j];
        end else if (j == extra_col && r == n) begin
          psum_valid[j]          = 1'b1;
          psum_in[j*PW +: PW]    = 24'h0003E7;
        end
      end
      saw_done = saw_done | done;
      tick();
    end
    psum_valid = '0;
    psum_in    = '0;
  endtask

  task automatic run_pass(input bit acc, input bit drn, input int n, input bit skew);
    do_start(acc, drn, n);
    drive_collect(n, skew);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; drain_en = 1'b0;
    num_rows = '0; psum_valid = '0; psum_in = '0; out_ready = 1'b0;
    tick(); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (out_row !== '0) $display("FAIL reset_out_row: got %0d want 0", out_row); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_overwrite_skew;
    logic [NC*AW-1:0] exp;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < NC; j++) v[r][j] = PW'((j + 1) * (r == 0 ? 1 : 10));
    out_ready = 1'b0;
    run_pass(1'b0, 1'b1, 2, 1'b1);
    n_total++; if (saw_done !== 1'b0) $display("FAIL skew_done_early: got %b want 0", saw_done); else n_pass++;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < NC; j++) exp[j*AW +: AW] = AW'((j + 1) * (r == 0 ? 1 : 10));
      n_total++; if (out_valid !== 1'b1) $display("FAIL skew_valid row %0d: got %b want 1", r, out_valid); else n_pass++;
      n_total++; if (out_row !== CW'(r)) $display("FAIL skew_row: got %0d want %0d", out_row, r); else n_pass++;
      n_total++; if (out_data !== exp) $display("FAIL skew_data row %0d: got %h want %h", r, out_data, exp); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL skew_done_drain row %0d: got %b want 0", r, done); else n_pass++;
      out_ready = 1'b1;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL skew_end_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL skew_end_done: got %b want 1", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL skew_end_busy: got %b want 0", busy); else n_pass++;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_two_tile;
    fill(24'd5);
    run_pass(1'b0, 1'b0, 2, 1'b0);
    n_total++; if (done !== 1'b1) $display("FAIL tile1_done: got %b want 1", done); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL tile1_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL tile1_busy: got %b want 0", busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL tile1_done_pulse: got %b want 0", done); else n_pass++;
    fill(24'hFFFFFD);
    run_pass(1'b1, 1'b1, 2, 1'b0);
    for (int r = 0; r < 2; r++) begin
      n_total++; if (out_row !== CW'(r)) $display("FAIL tile2_row: got %0d want %0d", out_row, r); else n_pass++;
      n_total++; if (out_data !== {NC{32'd2}}) $display("FAIL tile2_data row %0d: got %h want all 2", r, out_data); else n_pass++;
      out_ready = 1'b1;
      tick();
    end
    n_total++; if (done !== 1'b1) $display("FAIL tile2_done: got %b want 1", done); else n_pass++;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    int pat [6] = '{0, 0, 1, 0, 1, 1};
    int exp_row;
    logic [NC*AW-1:0] exp;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < NC; j++) v[r][j] = PW'(100 * r + j);
    run_pass(1'b0, 1'b1, 3, 1'b0);
    exp_row = 0;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < NC; j++) exp[j*AW +: AW] = AW'(100 * exp_row + j);
      out_ready = pat[k][0];
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid k=%0d: got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (out_row !== CW'(exp_row)) $display("FAIL bp_row k=%0d: got %0d want %0d", k, out_row, exp_row); else n_pass++;
      n_total++; if (out_data !== exp) $display("FAIL bp_data k=%0d: got %h want %h", k, out_data, exp); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL bp_done_early k=%0d: got %b want 0", k, done); else n_pass++;
      tick();
      if (pat[k] != 0) exp_row++;
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_end_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL bp_end_done: got %b want 1", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL bp_end_busy: got %b want 0", busy); else n_pass++;
    out_ready = 1'b0;
    tick();
  endtask

  // 256 * 0x7FFFFF + 0xFF = 0x7FFFFFFF, then +1 wraps to 0x80000000.
  task automatic test_wrap;
    fill(24'h7FFFFF);
    run_pass(1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 255; i++) run_pass(1'b1, 1'b0, 1, 1'b0);
    fill(24'h0000FF);
    run_pass(1'b1, 1'b0, 1, 1'b0);
    fill(24'h000001);
    run_pass(1'b1, 1'b1, 1, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_data !== {NC{32'h80000000}}) $display("FAIL wrap_data: got %h want all 80000000", out_data); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL wrap_err: got %b want 0", err); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (done !== 1'b1) $display("FAIL wrap_done: got %b want 1", done); else n_pass++;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_errors;
    logic [NC*AW-1:0] exp;
    num_rows = '0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    n_total++; if (err !== 1'b1) $display("FAIL err_zero_rows: got %b want 1", err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL err_zero_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL err_zero_done: got %b want 0", done); else n_pass++;

    for (int r = 0; r < NR; r++)
      for (int j = 0; j < NC; j++) v[r][j] = PW'(r * 4 + j + 1);
    extra_col = 2;
    run_pass(1'b0, 1'b1, 4, 1'b1);
    extra_col = -1;
    n_total++; if (err !== 1'b1) $display("FAIL err_overrun: got %b want 1", err); else n_pass++;
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j < NC; j++) exp[j*AW +: AW] = AW'(r * 4 + j + 1);
      n_total++; if (out_row !== CW'(r)) $display("FAIL err_drain_row: got %0d want %0d", out_row, r); else n_pass++;
      n_total++; if (out_data !== exp) $display("FAIL err_drain_data row %0d: got %h want %h", r, out_data, exp); else n_pass++;
      out_ready = 1'b1;
      tick();
    end
    n_total++; if (done !== 1'b1) $display("FAIL err_drain_done: got %b want 1", done); else n_pass++;
    out_ready = 1'b0;
    tick();

    fill('0);
    do_start(1'b1, 1'b0, 1);
    n_total++; if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL err_clear_busy: got %b want 1", busy); else n_pass++;
    drive_collect(1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_collect;
    fill(24'd7);
    do_start(1'b0, 1'b1, 3);
    psum_valid = '1;
    psum_in    = {NC{24'd7}};
    tick();
    psum_valid = '0;
    psum_in    = '0;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    fill('0);
    run_pass(1'b1, 1'b1, 4, 1'b0);
    for (int r = 0; r < NR; r++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL rstmid_drain_valid row %0d: got %b want 1", r, out_valid); else n_pass++;
      n_total++; if (out_data !== '0) $display("FAIL rstmid_drain_data row %0d: got %h want 0", r, out_data); else n_pass++;
      out_ready = 1'b1;
      tick();
    end
    n_total++; if (done !== 1'b1) $display("FAIL rstmid_done: got %b want 1", done); else n_pass++;
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_overwrite_skew();
    test_two_tile();
    test_backpressure();
    test_wrap();
    test_errors();
    test_reset_mid_collect();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
